ro_reg_bank: RTL and testbench

Multi-channel read-only status register bank on the CPU local register bus, the parametrised successor of the single-address read-only register instance. It maps NUM_CH status inputs of up to 64 bits each onto consecutive 32-bit word addresses starting at BASE_ADDR. Reads are registered and acknowledged with a one-cycle `cpu_rd_ack`. Reads of 64-bit values are atomic through a per-channel high-word snapshot. `cpu_data_out` is zero whenever no acknowledge is driven, so several banks can be OR-combined onto one read bus.

---
 rtl/ro_reg_pkg.sv | 18 +
 rtl/ro_reg_sticky.sv | 30 +++
 rtl/ro_reg_bank.sv | 112 +++++++++++
 tb/tb_ro_reg_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_reg_pkg.sv
// Shared constants and sizing helpers for the read-only status register bank.
package ro_reg_pkg;

   localparam int WORD_W    = 32;
   localparam int MAX_CH    = 16;
   localparam int MAX_VLD_W = 64;

   // One bus word covers values up to 32 bits; wider values take two.
   function automatic int words_per_ch(input int vld_width);
      return (vld_width <= WORD_W) ? 1 : 2;
   endfunction

   // Number of consecutive word addresses occupied by the whole bank.
   function automatic int bank_span(input int num_ch, input int vld_width);
      return num_ch * words_per_ch(vld_width);
   endfunction

endpackage

// File: rtl/ro_reg_sticky.sv
// Single-channel sticky accumulator: bits latch high until the channel is read.
// The clearing read reloads with the current input, so a bit rising in that
// same cycle survives into the next read.
module ro_reg_sticky #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] din_i,
   input  logic         clr_i,
   output logic [W-1:0] val_o
);

   logic [W-1:0] sticky_q;
   logic [W-1:0] sticky_d;

   // Accumulate new set bits, or restart from the live input on a clearing read.
   always_comb begin
      sticky_d = clr_i ? din_i : (sticky_q | din_i);
   end

   // Sticky state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sticky_q <= '0;
      else       sticky_q <= sticky_d;
   end

   assign val_o = sticky_q;

endmodule

// File: rtl/ro_reg_bank.sv
// Multi-channel read-only status register bank on the CPU local register bus.
// Channel i word w sits at BASE_ADDR + i*WPC + w. Reads return one cycle later
// with a single-cycle acknowledge; data is zero whenever no acknowledge is
// driven so several banks can be OR-combined. Values wider than 32 bits are
// read atomically: the word 0 read snapshots the high part into a per-channel
// hold register that the word 1 read returns.
// Optional feature: define RO_REG_STICKY_EN for latch-until-read status bits.
module ro_reg_bank
   import ro_reg_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int VLD_WIDTH  = 32,
   parameter int ADDR_WIDTH = 13,
   parameter int BASE_ADDR  = 0
) (
   input  logic                        clks,
   input  logic                        reset,
   input  logic                        cpu_rd,
   input  logic [ADDR_WIDTH-1:0]       cpu_addr,
   input  logic [NUM_CH*VLD_WIDTH-1:0] din,
   output logic                        cpu_rd_ack,
   output logic [WORD_W-1:0]           cpu_data_out
);

   localparam int WPC  = words_per_ch(VLD_WIDTH);
   localparam int LO_W = (VLD_WIDTH > WORD_W) ? WORD_W : VLD_WIDTH;
   localparam int HI_W = (VLD_WIDTH > WORD_W) ? (VLD_WIDTH - WORD_W) : 1;

   logic [VLD_WIDTH-1:0] val       [NUM_CH];
   logic [WORD_W-1:0]    lo_word   [NUM_CH];
   logic [WORD_W-1:0]    hold_word [NUM_CH];

   logic                 rd_hit;
   logic [NUM_CH-1:0]    ch_hit;
   logic                 word_sel;
   logic [WORD_W-1:0]    rdata_d;
   logic                 ack_q;
   logic [WORD_W-1:0]    rdata_q;

   // Address decode: exact match against every mapped word of the bank.
   always_comb begin
      rd_hit   = 1'b0;
      ch_hit   = '0;
      word_sel = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         for (int w = 0; w < WPC; w++) begin
            if (cpu_rd && (cpu_addr == ADDR_WIDTH'(BASE_ADDR + i*WPC + w))) begin
               rd_hit    = 1'b1;
               ch_hit[i] = 1'b1;
               word_sel  = (w == 1);
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef RO_REG_STICKY_EN
      logic clr;
      // Only a read of the channel's last word releases its sticky bits.
      assign clr = ch_hit[i] && ((WPC == 1) || word_sel);

      ro_reg_sticky #(.W(VLD_WIDTH)) u_sticky (
         .clk_i (clks),
         .rst_i (reset),
         .din_i (din[i*VLD_WIDTH +: VLD_WIDTH]),
         .clr_i (clr),
         .val_o (val[i])
      );
`else
      assign val[i] = din[i*VLD_WIDTH +: VLD_WIDTH];
`endif

      assign lo_word[i] = WORD_W'(val[i][LO_W-1:0]);

      if (WPC == 2) begin : g_hold
         logic [HI_W-1:0] hold_q;

         // Snapshot the high part on a word 0 read; word 1 reads leave it alone.
         always_ff @(posedge clks or posedge reset) begin
            if (reset)                     hold_q <= '0;
            else if (ch_hit[i] && !word_sel) hold_q <= val[i][VLD_WIDTH-1:WORD_W];
         end

         assign hold_word[i] = WORD_W'(hold_q);
      end else begin : g_no_hold
         assign hold_word[i] = '0;
      end
   end

   // Read data mux; zero when nothing hits so the bus stays OR-able.
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_hit[i]) rdata_d = word_sel ? hold_word[i] : lo_word[i];
      end
   end

   // Output stage: one-cycle acknowledge with its data.
   always_ff @(posedge clks or posedge reset) begin
      if (reset) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= rd_hit;
         rdata_q <= rdata_d;
      end
   end

   assign cpu_rd_ack   = ack_q;
   assign cpu_data_out = rdata_q;

endmodule

// File: tb/tb_ro_reg_bank.sv
// Directed bench for ro_reg_bank using four instances of different widths.
module tb_ro_reg_bank;

   logic clks = 1'b0;
   logic reset;

   // a: 4 x 32-bit at 0x100
   logic         rd_a;
   logic [12:0]  addr_a;
   logic [127:0] din_a;
   logic         ack_a;
   logic [31:0]  dout_a;
   // b: 2 x 64-bit at 0x200
   logic         rd_b;
   logic [12:0]  addr_b;
   logic [127:0] din_b;
   logic         ack_b;
   logic [31:0]  dout_b;
   // c: 1 x 12-bit at 0x010
   logic         rd_c;
   logic [12:0]  addr_c;
   logic [11:0]  din_c;
   logic         ack_c;
   logic [31:0]  dout_c;
   // d: 2 x 8-bit at 0x000
   logic         rd_d;
   logic [12:0]  addr_d;
   logic [15:0]  din_d;
   logic         ack_d;
   logic [31:0]  dout_d;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clks = ~clks;

   ro_reg_bank #(.NUM_CH(4), .VLD_WIDTH(32), .ADDR_WIDTH(13), .BASE_ADDR(32'h100)) u_a (
      .clks(clks), .reset(reset), .cpu_rd(rd_a), .cpu_addr(addr_a), .din(din_a),
      .cpu_rd_ack(ack_a), .cpu_data_out(dout_a));

   ro_reg_bank #(.NUM_CH(2), .VLD_WIDTH(64), .ADDR_WIDTH(13), .BASE_ADDR(32'h200)) u_b (
      .clks(clks), .reset(reset), .cpu_rd(rd_b), .cpu_addr(addr_b), .din(din_b),
      .cpu_rd_ack(ack_b), .cpu_data_out(dout_b));

   ro_reg_bank #(.NUM_CH(1), .VLD_WIDTH(12), .ADDR_WIDTH(13), .BASE_ADDR(32'h010)) u_c (
      .clks(clks), .reset(reset), .cpu_rd(rd_c), .cpu_addr(addr_c), .din(din_c),
      .cpu_rd_ack(ack_c), .cpu_data_out(dout_c));

   ro_reg_bank #(.NUM_CH(2), .VLD_WIDTH(8), .ADDR_WIDTH(13), .BASE_ADDR(0)) u_d (
      .clks(clks), .reset(reset), .cpu_rd(rd_d), .cpu_addr(addr_d), .din(din_d),
      .cpu_rd_ack(ack_d), .cpu_data_out(dout_d));

   task automatic test_reset();
      reset = 1'b1;
      rd_a = 0; rd_b = 0; rd_c = 0; rd_d = 0;
      addr_a = '0; addr_b = '0; addr_c = '0; addr_d = '0;
      din_a = '0; din_b = '0; din_c = '0; din_d = '0;
      #2;
      n_checks++;
      if (ack_a !== 1'b0 || dout_a !== 32'h0) begin
         n_fail++; $display("FAIL reset_a: ack=%b data=%h expected ack=0 data=00000000", ack_a, dout_a);
      end
      n_checks++;
      if (ack_b !== 1'b0 || dout_b !== 32'h0) begin
         n_fail++; $display("FAIL reset_b: ack=%b data=%h expected ack=0 data=00000000", ack_b, dout_b);
      end
      repeat (3) @(negedge clks);
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      logic [31:0] addrs [3] = '{32'h102, 32'h100, 32'h103};
      logic [31:0] exps  [3] = '{32'hDEADBEEF, 32'h11111111, 32'h33333333};
      din_a = {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
      for (int k = 0; k < 3; k++) begin
         @(negedge clks);
         rd_a = 1'b1; addr_a = addrs[k][12:0];
         n_checks++;
         if (ack_a !== 1'b0 || dout_a !== 32'h0) begin
            n_fail++; $display("FAIL read_pre_%0d: ack=%b data=%h expected ack=0 data=0", k, ack_a, dout_a);
         end
         @(negedge clks);
         rd_a = 1'b0;
         n_checks++;
         if (ack_a !== 1'b1 || dout_a !== exps[k]) begin
            n_fail++; $display("FAIL read_%0d: ack=%b data=%h expected ack=1 data=%h", k, ack_a, dout_a, exps[k]);
         end
         @(negedge clks);
         n_checks++;
         if (ack_a !== 1'b0 || dout_a !== 32'h0) begin
            n_fail++; $display("FAIL read_post_%0d: ack=%b data=%h expected ack=0 data=0", k, ack_a, dout_a);
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [12:0] addrs [2] = '{13'h104, 13'h0FF};
      for (int k = 0; k < 2; k++) begin
         @(negedge clks);
         rd_a = 1'b1; addr_a = addrs[k];
         @(negedge clks);
         rd_a = 1'b0;
         n_checks++;
         if (ack_a !== 1'b0 || dout_a !== 32'h0) begin
            n_fail++; $display("FAIL miss_%h: ack=%b data=%h expected ack=0 data=0", addrs[k], ack_a, dout_a);
         end
      end
   endtask

   task automatic test_snapshot();
      // word 1 before any word 0 read returns the reset snapshot
      @(negedge clks);
      rd_b = 1'b1; addr_b = 13'h203;
      @(negedge clks);
      rd_b = 1'b0;
      n_checks++;
      if (ack_b !== 1'b1 || dout_b !== 32'h0) begin
         n_fail++; $display("FAIL snap_reset_w1: ack=%b data=%h expected ack=1 data=00000000", ack_b, dout_b);
      end
      din_b[127:64] = 64'h0000_0001_FFFF_FFFF;
      @(negedge clks);
      rd_b = 1'b1; addr_b = 13'h202;
      @(negedge clks);
      rd_b = 1'b0;
      din_b[127:64] = 64'h0000_0002_0000_0000;
      n_checks++;
      if (ack_b !== 1'b1 || dout_b !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL snap_w0: ack=%b data=%h expected ack=1 data=ffffffff", ack_b, dout_b);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clks);
         rd_b = 1'b1; addr_b = 13'h203;
         @(negedge clks);
         rd_b = 1'b0;
         n_checks++;
         if (ack_b !== 1'b1 || dout_b !== 32'h00000001) begin
            n_fail++; $display("FAIL snap_w1_%0d: ack=%b data=%h expected ack=1 data=00000001", k, ack_b, dout_b);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] addrs [4] = '{13'h200, 13'h202, 13'h201, 13'h203};
      logic [31:0] exps  [4] = '{32'h0000000A, 32'h0000000B, 32'h0000AAAA, 32'h0000BBBB};
      din_b = {32'h0000BBBB, 32'h0000000B, 32'h0000AAAA, 32'h0000000A};
      for (int k = 0; k < 4; k++) begin
         @(negedge clks);
         if (k > 0) begin
            n_checks++;
            if (ack_b !== 1'b1 || dout_b !== exps[k-1]) begin
               n_fail++; $display("FAIL b2b_%0d: ack=%b data=%h expected ack=1 data=%h", k-1, ack_b, dout_b, exps[k-1]);
            end
         end
         if (k == 1) din_b[63:0]   = '0;
         if (k == 2) din_b[127:64] = '0;
         rd_b = 1'b1; addr_b = addrs[k];
      end
      @(negedge clks);
      rd_b = 1'b0;
      n_checks++;
      if (ack_b !== 1'b1 || dout_b !== exps[3]) begin
         n_fail++; $display("FAIL b2b_3: ack=%b data=%h expected ack=1 data=%h", ack_b, dout_b, exps[3]);
      end
      @(negedge clks);
      n_checks++;
      if (ack_b !== 1'b0 || dout_b !== 32'h0) begin
         n_fail++; $display("FAIL b2b_end: ack=%b data=%h expected ack=0 data=0", ack_b, dout_b);
      end
   endtask

   task automatic test_narrow();
      din_c = 12'hFFF;
      @(negedge clks);
      rd_c = 1'b1; addr_c = 13'h010;
      @(negedge clks);
      rd_c = 1'b1; addr_c = 13'h011;
      n_checks++;
      if (ack_c !== 1'b1 || dout_c !== 32'h00000FFF) begin
         n_fail++; $display("FAIL narrow: ack=%b data=%h expected ack=1 data=00000fff", ack_c, dout_c);
      end
      @(negedge clks);
      rd_c = 1'b0;
      n_checks++;
      if (ack_c !== 1'b0 || dout_c !== 32'h0) begin
         n_fail++; $display("FAIL narrow_miss: ack=%b data=%h expected ack=0 data=0", ack_c, dout_c);
      end
   endtask

`ifdef RO_REG_STICKY_EN
   task automatic test_sticky();
      din_d = '0;
      @(negedge clks);
      din_d = 16'h0008;
      @(negedge clks);
      din_d = 16'h0000;
      rd_d = 1'b1; addr_d = 13'h000;
      @(negedge clks);
      rd_d = 1'b0;
      n_checks++;
      if (ack_d !== 1'b1 || dout_d !== 32'h08) begin
         n_fail++; $display("FAIL sticky_first: ack=%b data=%h expected ack=1 data=00000008", ack_d, dout_d);
      end
      @(negedge clks);
      rd_d = 1'b1; addr_d = 13'h000; din_d = 16'h0020;
      @(negedge clks);
      rd_d = 1'b0; din_d = 16'h0000;
      n_checks++;
      if (ack_d !== 1'b1 || dout_d !== 32'h00) begin
         n_fail++; $display("FAIL sticky_cleared: ack=%b data=%h expected ack=1 data=00000000", ack_d, dout_d);
      end
      @(negedge clks);
      rd_d = 1'b1; addr_d = 13'h000;
      @(negedge clks);
      rd_d = 1'b0;
      n_checks++;
      if (ack_d !== 1'b1 || dout_d !== 32'h20) begin
         n_fail++; $display("FAIL sticky_same_cycle: ack=%b data=%h expected ack=1 data=00000020", ack_d, dout_d);
      end
   endtask
`else
   task automatic test_live();
      din_d = 16'h5AC3;
      @(negedge clks);
      rd_d = 1'b1; addr_d = 13'h001;
      @(negedge clks);
      rd_d = 1'b1; addr_d = 13'h000; din_d = 16'h5A3C;
      n_checks++;
      if (ack_d !== 1'b1 || dout_d !== 32'h5A) begin
         n_fail++; $display("FAIL live_ch1: ack=%b data=%h expected ack=1 data=0000005a", ack_d, dout_d);
      end
      @(negedge clks);
      rd_d = 1'b0;
      n_checks++;
      if (ack_d !== 1'b1 || dout_d !== 32'h3C) begin
         n_fail++; $display("FAIL live_ch0: ack=%b data=%h expected ack=1 data=0000003c", ack_d, dout_d);
      end
   endtask
`endif

   task automatic test_reset_mid_read();
      @(negedge clks);
      rd_a = 1'b1; addr_a = 13'h102;
      @(posedge clks);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (ack_a !== 1'b0 || dout_a !== 32'h0) begin
         n_fail++; $display("FAIL reset_drop: ack=%b data=%h expected ack=0 data=0", ack_a, dout_a);
      end
      @(negedge clks);
      n_checks++;
      if (ack_a !== 1'b0 || dout_a !== 32'h0) begin
         n_fail++; $display("FAIL reset_strobe: ack=%b data=%h expected ack=0 data=0", ack_a, dout_a);
      end
      reset = 1'b0;
      rd_b = 1'b1; addr_b = 13'h203;
      @(negedge clks);
      rd_a = 1'b0; rd_b = 1'b0;
      n_checks++;
      if (ack_a !== 1'b1 || dout_a !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL first_after_reset: ack=%b data=%h expected ack=1 data=deadbeef", ack_a, dout_a);
      end
      n_checks++;
      if (ack_b !== 1'b1 || dout_b !== 32'h0) begin
         n_fail++; $display("FAIL hold_after_reset: ack=%b data=%h expected ack=1 data=00000000", ack_b, dout_b);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_out_of_range();
      test_snapshot();
      test_back_to_back();
      test_narrow();
`ifdef RO_REG_STICKY_EN
      test_sticky();
`else
      test_live();
`endif
      test_reset_mid_read();
      repeat (2) @(negedge clks);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
